// File: rtl/alu_req_sched.sv
`default_nettype none
// ============================================================================
// Module  : alu_req_sched
// Purpose : round-robin arbiter sharing one single-cycle ALU among NREQ units
// Revision: 1.0
// ============================================================================
module alu_req_sched #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [NREQ*W-1:0]   req_a_i,
  input  logic [NREQ*W-1:0]   req_b_i,
  input  logic [NREQ*4-1:0]   req_op_i,
  output logic [W-1:0]        alu_a_o,
  output logic [W-1:0]        alu_b_o,
  output logic [3:0]          alu_op_o,
  input  logic [W-1:0]        alu_result_i,
  output logic [NREQ-1:0]     rsp_valid_o,
  input  logic [NREQ-1:0]     rsp_ready_i,
  output logic [W-1:0]        rsp_data_o,
  output logic                busy_o,
  output logic [2:0]          grant_id_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      grant_q, grant_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [3:0]      op_q, op_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [7:0]      valid_ext;
  logic [7:0]      rsp_ready_ext;
  logic            found;
  logic [2:0]      gnt;
  logic [3:0]      idx;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [3:0]      sel_op;

  // Pad to 8 bits so a 3-bit requester index can address any NREQ.
  assign valid_ext     = 8'(req_valid_i);
  assign rsp_ready_ext = 8'(rsp_ready_i);

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] id);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (id == 3'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    gnt   = 3'd0;
    idx   = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (!found && valid_ext[idx[2:0]]) begin
        found = 1'b1;
        gnt   = idx[2:0];
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == 3'(i)) begin
        sel_a  = req_a_i[i*W +: W];
        sel_b  = req_b_i[i*W +: W];
        sel_op = req_op_i[i*4 +: 4];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_o = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready_o = onehot(gnt) & {NREQ{rst_n}};
          a_d         = sel_a;
          b_d         = sel_b;
          op_d        = sel_op;
          grant_d     = gnt;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rsp_data_d  = alu_result_i;
        rsp_valid_d = onehot(grant_q);
        state_d     = S_RESP;
      end
      S_RESP: begin
        // Only the granted requester's rsp_ready completes the response.
        if (rsp_ready_ext[grant_q]) begin
          rsp_valid_d = '0;
          ptr_d       = (grant_q == 3'(NREQ-1)) ? 3'd0 : grant_q + 3'd1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 3'd0;
      grant_q     <= 3'd0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 4'd0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_op_o    = op_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_valid_o = rsp_valid_q;
  assign busy_o      = (state_q != S_IDLE);
  assign grant_id_o  = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_req_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_req_sched
// Purpose : self-checking bench for alu_req_sched with a behavioural ALU model
// Revision: 1.0
// ============================================================================
module tb_alu_req_sched;
  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*4-1:0] req_op;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [3:0]        alu_op;
  logic [W-1:0]      alu_result;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_data;
  logic              busy;
  logic [2:0]        grant_id;

  logic [NREQ-1:0]   v;
  logic [W-1:0]      ra [NREQ];
  logic [W-1:0]      rb [NREQ];
  logic [3:0]        rop[NREQ];

  int  checks = 0;
  int  errors = 0;
  int  mptr   = 0;
  time acc_t;
  time acc_hist[5];

  alu_req_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_result_i(alu_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .busy_o(busy), .grant_id_o(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  // The ALU instance the scheduler feeds.
  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  always_comb begin
    req_valid = v;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W]  = ra[i];
      req_b[i*W +: W]  = rb[i];
      req_op[i*4 +: 4] = rop[i];
    end
  end

  function automatic logic [NREQ-1:0] oh(input int g);
    logic [NREQ-1:0] r;
    r    = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  // Round-robin reference: first pending requester at or after ptr.
  function automatic int pick(input logic [NREQ-1:0] pend, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept in IDLE, ALU drive, response with 'stall' wait cycles.
  task automatic txn(input int g, input int stall, input logic [W-1:0] exp_d, input bit keep);
    logic [W-1:0]    ea, eb;
    logic [3:0]      eo;
    logic [NREQ-1:0] junk;
    ea = ra[g];
    eb = rb[g];
    eo = rop[g];
    @(negedge clk);
    chk("req_ready_accept", 64'(req_ready), 64'(oh(g)));
    chk("busy_idle", 64'(busy), 64'd0);
    chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
    acc_t = $time;
    tick();
    if (!keep) v[g] = 1'b0;
    @(negedge clk);
    chk("alu_a", 64'(alu_a), 64'(ea));
    chk("alu_b", 64'(alu_b), 64'(eb));
    chk("alu_op", 64'(alu_op), 64'(eo));
    chk("grant_id", 64'(grant_id), 64'(g));
    chk("busy_issue", 64'(busy), 64'd1);
    chk("req_ready_issue", 64'(req_ready), 64'd0);
    tick();
    for (int s = 0; s <= stall; s++) begin
      junk      = NREQ'($urandom);
      rsp_ready = (s < stall) ? (junk & ~oh(g)) : (junk | oh(g));
      @(negedge clk);
      chk("rsp_valid", 64'(rsp_valid), 64'(oh(g)));
      chk("rsp_data", 64'(rsp_data), 64'(exp_d));
      chk("req_ready_resp", 64'(req_ready), 64'd0);
      chk("busy_resp", 64'(busy), 64'd1);
      tick();
    end
    rsp_ready = '0;
    mptr      = (g + 1) % NREQ;
  endtask

  typedef struct {
    int          r;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 4'h0, 32'd5,          32'd7,          32'd12};
    tbl[1] = '{3, 4'h1, 32'd3,          32'd5,          32'hFFFF_FFFE};
    tbl[2] = '{2, 4'h2, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
    tbl[3] = '{1, 4'h3, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678};
    tbl[4] = '{0, 4'h4, 32'hAAAA_AAAA,  32'hFFFF_FFFF,  32'h5555_5555};
    tbl[5] = '{2, 4'h5, 32'hFFFF_FFFF,  32'd1,          32'd1};
    tbl[6] = '{0, 4'h5, 32'd1,          32'hFFFF_FFFF,  32'd0};
    tbl[7] = '{1, 4'hF, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0};
    tbl[8] = '{3, 4'h6, 32'd9,          32'd4,          32'd0};

    rst_n     = 1'b0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = '0; rb[i] = '0; rop[i] = '0;
    end
    v = '1;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    v = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed single-request vectors, including illegal op codes.
    for (int t = 0; t < 9; t++) begin
      ra[tbl[t].r]  = tbl[t].a;
      rb[tbl[t].r]  = tbl[t].b;
      rop[tbl[t].r] = tbl[t].op;
      v             = oh(tbl[t].r);
      txn(tbl[t].r, 0, tbl[t].exp, 1'b0);
    end

    // Fairness: all four continuously valid, pointer starts at 0.
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = 32'(100 + i); rb[i] = 32'(7 * i + 1); rop[i] = 4'(i);
    end
    v = '1;
    for (int j = 0; j < 5; j++) begin
      txn(j % NREQ, 0, alu_f(rop[j % NREQ], ra[j % NREQ], rb[j % NREQ]), 1'b1);
      acc_hist[j] = acc_t;
    end
    for (int j = 1; j < 5; j++) chk("accept_spacing", 64'(acc_hist[j] - acc_hist[j-1]), 64'd30);
    v = '0;

    // Backpressure on requester 2 with requester 1 pending.
    ra[1] = 32'd1; rb[1] = 32'd2; rop[1] = 4'h0;
    v = oh(1);
    txn(1, 0, 32'd3, 1'b0);
    ra[2] = 32'd3; rb[2] = 32'd5; rop[2] = 4'h1;
    ra[1] = 32'd8; rb[1] = 32'd8; rop[1] = 4'h4;
    v = oh(2) | oh(1);
    txn(2, 4, 32'hFFFF_FFFE, 1'b0);
    txn(1, 0, 32'd0, 1'b0);

    // Pointer wrap after a grant to 3.
    ra[3] = 32'd2; rb[3] = 32'd2; rop[3] = 4'h0;
    v = oh(3);
    txn(3, 0, 32'd4, 1'b0);
    ra[0] = 32'd6; rb[0] = 32'd3; rop[0] = 4'h2;
    ra[2] = 32'd6; rb[2] = 32'd3; rop[2] = 4'h3;
    v = oh(0) | oh(2);
    txn(0, 0, 32'd2, 1'b0);
    txn(2, 0, 32'd7, 1'b0);

    // Reset while the response to requester 3 is pending.
    ra[3] = 32'd40; rb[3] = 32'd2; rop[3] = 4'h0;
    v = oh(3);
    @(negedge clk);
    chk("rstmid_accept", 64'(req_ready), 64'(oh(3)));
    tick();
    v = '0;
    tick();
    @(negedge clk);
    chk("rstmid_resp_pending", 64'(rsp_valid), 64'(oh(3)));
    #2;
    rst_n = 1'b0;
    v     = oh(1) | oh(3);
    #1;
    chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_grant_id", 64'(grant_id), 64'd0);
    chk("rstmid_alu_a", 64'(alu_a), 64'd0);
    chk("rstmid_rsp_data", 64'(rsp_data), 64'd0);
    chk("rstmid_req_ready", 64'(req_ready), 64'd0);
    mptr = 0;
    v    = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    tick();
    ra[1] = 32'd11; rb[1] = 32'd1; rop[1] = 4'h1;
    v = oh(1) | oh(3);
    txn(1, 0, 32'd10, 1'b0);
    txn(3, 0, 32'd42, 1'b0);

    // Randomized traffic against the round-robin reference.
    for (int n = 0; n < 60; n++) begin
      int g;
      logic [NREQ-1:0] save;
      if ($urandom_range(0, 3) == 0) begin
        save = v;
        v    = '0;
        @(negedge clk);
        chk("rand_idle_ready", 64'(req_ready), 64'd0);
        chk("rand_idle_busy", 64'(busy), 64'd0);
        tick();
        v = save;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i]   = 1'b1;
          ra[i]  = $urandom;
          rb[i]  = ($urandom_range(0, 3) == 0) ? ra[i] : $urandom;
          rop[i] = 4'($urandom_range(0, 7));
        end
      end
      if (v == '0) v[$urandom_range(0, NREQ-1)] = 1'b1;
      g = pick(v, mptr);
      txn(g, $urandom_range(0, 2), alu_f(rop[g], ra[g], rb[g]), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_req_sched.md
# alu_req_sched

Round-robin scheduler that shares the single-cycle integer ALU (ADD/SUB/AND/OR/XOR/SLT, 4-bit op code) between NREQ requesters. It sits between the requesting units and the ALU instance: it accepts one request per operation through a valid/ready handshake and drives the ALU operand/op inputs from registers. It captures the ALU result and returns it to the granting requester through a held response handshake.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 32, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept strobe (one-hot or zero)
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_op  in  NREQ*4  op code, requester i at bits [i*4 +: 4]
- alu_a  out  W  operand A to ALU
- alu_b  out  W  operand B to ALU
- alu_op  out  4  op code to ALU
- alu_result  in  W  combinational ALU result
- rsp_valid  out  NREQ  one-hot response valid
- rsp_ready  in  NREQ  per-requester response accept
- rsp_data  out  W  captured result
- busy  out  1  high in any state other than IDLE
- grant_id  out  3  index of current/last granted requester

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE:
  - Search req_valid starting at priority pointer ptr, wrapping modulo NREQ; the first set bit is the grant g.
  - If a grant exists: req_ready[g]=1 combinationally in the same cycle. On the clock edge, latch req_a/b/op of g into the operand registers, set grant_id=g, and go to ISSUE.
  - If no request is pending: req_ready is all zero and the FSM stays in IDLE.
- ISSUE: alu_a/alu_b/alu_op show the latched values. At the clock edge, rsp_data <= alu_result, rsp_valid[g] <= 1, and the FSM goes to RESP.
- RESP:
  - rsp_valid[g] and rsp_data stay constant until rsp_ready[g]=1.
  - On that edge: rsp_valid is cleared, ptr <= (g+1) mod NREQ, and the FSM goes to IDLE.
  - rsp_ready bits of other requesters are ignored.
- req_ready is zero in ISSUE and RESP. New requests are not accepted until the next IDLE cycle, so at most one operation is in flight.
- Op codes are passed through unchanged. Codes outside 0000..0101 make the ALU return 0, and the scheduler returns 0 as a normal response.
- Operand registers hold their values outside ISSUE; alu_* outputs are meaningful only in ISSUE.
- Requesters must not make req_valid depend combinationally on req_ready. A requester drops or changes its request only after seeing req_ready.
- An invalid NREQ (outside 2..8) is a configuration error; no runtime handling is provided.

## Timing
- Reset (asynchronous assert, released synchronously to clk):
  - state=IDLE, ptr=0, grant_id=0
  - alu_a=alu_b=0, alu_op=0000
  - rsp_data=0, rsp_valid=0, busy=0
  - req_ready is 0 while rst_n is low.
- Latency: accept at cycle T; ALU driven in T+1; rsp_valid is high from T+2.
- With rsp_ready held high, rsp_valid lasts one cycle (T+2) and the next accept can happen at T+3. Peak throughput is one operation per 3 cycles.
- Backpressure: each cycle of rsp_ready low in RESP adds one cycle, and all outputs are held.
- Simultaneous requests: only one is granted per IDLE cycle. The others must keep req_valid asserted.
- Reset mid-operation (ISSUE or RESP): the in-flight operation is discarded, no response is produced, and ptr returns to 0.
- busy rises on the cycle after the accept edge and falls on the edge that leaves RESP.

## Test plan
- Single request: requester 0 sends ADD 5+7 at T, with rsp_ready=1. Expect req_ready[0]=1 at T; in T+1, alu_op=0000, alu_a=5, alu_b=7; at T+2, rsp_valid=0001 and rsp_data=12; busy is high during T+1..T+2.
- Fairness: requesters 0 to 3 all continuously valid with distinct ops. Expect grants in order 0,1,2,3,0, with a new accept every 3 cycles.
- Backpressure: requester 2 sends SUB 3-5 and rsp_ready[2] is held low for 4 cycles. Expect rsp_data=0xFFFFFFFE and rsp_valid=0100 held for 5 cycles. Expect req_ready=0 for all requesters during that time, even with requester 1 pending.
- Pointer wrap: last grant was 3; requesters 0 and 2 are valid. Expect grant 0 first, then 2.
- Illegal op: requester 1 sends op 1111 with A=B=0xFFFFFFFF. Expect rsp_data=0 and rsp_valid=0010.
- Reset mid-op: assert rst_n=0 in RESP. Expect all outputs at their reset values immediately, no response after release, and the first grant after release searched from requester 0.
